// File: rtl/con_ff_unit.sv
// Branch-condition flip-flop: evaluates the C2 field of IR against the bus
// and registers the result when CON_in is asserted.
module con_ff_unit (
  input  logic        clock,
  input  logic        con_FF_Reset,
  input  logic [31:0] IR,
  input  logic [31:0] bus,
  input  logic        CON_in,
  output logic        CON_out
);

  logic        [1:0]  c2;
  logic signed [31:0] bus_s;
  logic               bus_zero;
  logic               bus_neg;
  logic               cond_d;
  logic               con_q;
  logic               unused_ir;

  assign c2        = IR[20:19];
  assign bus_s     = $signed(bus);
  assign bus_zero  = ~(|bus_s);
  assign bus_neg   = bus_s[31];
  assign unused_ir = ^{IR[31:21], IR[18:0]};

  always_comb begin
    cond_d = 1'b0;
    case (c2)
      2'b00:   cond_d = bus_zero;
      2'b01:   cond_d = ~bus_zero;
      2'b10:   cond_d = ~bus_neg;
      2'b11:   cond_d = bus_neg;
      default: cond_d = 1'b0;
    endcase
  end

  // Stage boundary: condition register, output taken straight from the flop
  always_ff @(posedge clock or negedge con_FF_Reset) begin
    if (!con_FF_Reset) begin
      con_q <= 1'b0;
    end else if (CON_in) begin
      con_q <= cond_d;
    end
  end

  assign CON_out = con_q;

endmodule

// File: tb/tb_con_ff_unit.sv
// Directed bench for con_ff_unit; expected outputs queued at drive time
// and compared one clock edge later.
module tb_con_ff_unit;

  logic        clock;
  logic        con_FF_Reset;
  logic [31:0] IR;
  logic [31:0] bus;
  logic        CON_in;
  logic        CON_out;

  logic        sb_q[$];
  int          n_checks;
  int          n_fails;

  con_ff_unit dut (
    .clock        (clock),
    .con_FF_Reset (con_FF_Reset),
    .IR           (IR),
    .bus          (bus),
    .CON_in       (CON_in),
    .CON_out      (CON_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag);
    logic exp;
    exp = sb_q.pop_front();
    n_checks++;
    assert (CON_out === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, CON_out, exp);
    end
  endtask

  task automatic step(input logic [31:0] ir, input logic [31:0] b,
                      input logic en, input logic exp, input string tag);
    @(negedge clock);
    IR     = ir;
    bus    = b;
    CON_in = en;
    sb_q.push_back(exp);
    @(posedge clock);
    #1;
    check(tag);
  endtask

  initial begin
    logic [31:0] ir_x;
    n_checks     = 0;
    n_fails      = 0;
    con_FF_Reset = 1'b0;
    CON_in       = 1'b0;
    IR           = 32'h0;
    bus          = 32'h0;
    ir_x         = {11'bx, 2'b00, 19'bx};

    #1;
    sb_q.push_back(1'b0);
    check("reset_initial");

    // Reset held low: enable with a true condition must not load
    step(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "rst_hold_a");
    step(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "rst_hold_b");

    @(negedge clock);
    CON_in       = 1'b0;
    con_FF_Reset = 1'b1;
    step(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "post_rst_idle");

    step(32'h0018_0000, 32'h8000_0000, 1'b1, 1'b1, "c11_pulse");
    step(32'h0018_0000, 32'h0000_0000, 1'b0, 1'b1, "c11_hold");

    // Async reset between edges
    @(negedge clock);
    #2;
    con_FF_Reset = 1'b0;
    sb_q.push_back(1'b0);
    #1;
    check("async_rst");
    @(negedge clock);
    con_FF_Reset = 1'b1;

    step(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, "c00_zero");
    step(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, "c00_one");
    step(32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, "c00_min");

    step(32'h0008_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "c01_ones");
    step(32'h0008_0000, 32'h0000_0000, 1'b1, 1'b0, "c01_zero");
    step(32'h0008_0000, 32'h8000_0000, 1'b1, 1'b1, "c01_min");

    step(32'h0010_0000, 32'h0000_0000, 1'b1, 1'b1, "c10_zero");
    step(32'h0010_0000, 32'h8000_0000, 1'b1, 1'b0, "c10_min");
    step(32'h0010_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, "c10_max");

    step(32'h0018_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "c11_max");
    step(32'h0018_0000, 32'h8000_0000, 1'b1, 1'b1, "c11_min");

    for (int k = 0; k < 3; k++) begin
      step(32'h0000_0000, 32'h0000_0005, 1'b0, 1'b1, "hold_cond0");
    end

    // Inputs changing after the capturing edge must not reach the output
    step(32'h0000_0000, 32'h0000_0005, 1'b1, 1'b0, "cap_zero");
    bus = 32'h0000_0000;
    sb_q.push_back(1'b0);
    #2;
    check("post_cap_change");

    step(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, "pre_prio");
    @(negedge clock);
    IR           = 32'h0000_0000;
    bus          = 32'h0000_0000;
    CON_in       = 1'b1;
    con_FF_Reset = 1'b0;
    sb_q.push_back(1'b0);
    @(posedge clock);
    #1;
    check("prio_rst");
    @(negedge clock);
    CON_in       = 1'b0;
    con_FF_Reset = 1'b1;
    step(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "prio_after");

    step(32'hFFE7_FFFF, 32'h0000_0000, 1'b1, 1'b1, "ir_unused_zero");
    step(32'hFFE7_FFFF, 32'h0000_0001, 1'b1, 1'b0, "ir_unused_nz");
    step(ir_x,          32'h0000_0000, 1'b1, 1'b1, "ir_x_zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
